// File: rtl/conv_layer_scheduler.sv
// Control sequencer for the conv datapath: walks the pixel ROM, starts one output-row
// calculation at a time per kernel and hands finished rows to pooling with valid/ready.
module conv_layer_scheduler #(
  parameter int unsigned IMAGE_SIZE     = 8,
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned FEATURE_NUM    = 3,
  parameter int unsigned EXT_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      calc_done,
  input  logic                      pool_ready,
  output logic [EXT_ADDR_WIDTH-1:0] ext_rom_addr,
  output logic                      fetch_valid,
  output logic                      calc_start,
  output logic                      kernel_calc_fin,
  output logic [2:0]                out_row_idx,
  output logic [1:0]                feature_idx,
  output logic                      busy,
  output logic                      layer_done
);

  localparam int unsigned OUT_SIZE    = IMAGE_SIZE - KERNEL_SIZE + 1;
  localparam int unsigned PRELOAD_LEN = KERNEL_SIZE * IMAGE_SIZE;
  localparam int unsigned CNT_W       = $clog2(PRELOAD_LEN + 1);

  localparam logic [CNT_W-1:0] PRELOAD_LAST = CNT_W'(PRELOAD_LEN - 1);
  localparam logic [CNT_W-1:0] SHIFT_LAST   = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [2:0]       ROW_LAST     = 3'(OUT_SIZE - 1);
  localparam logic [1:0]       FEAT_LAST    = 2'(FEATURE_NUM - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreload,
    StCalc,
    StEmit,
    StShift,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          fcnt_q, fcnt_d;
  logic [EXT_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]                row_q, row_d;
  logic [1:0]                feat_q, feat_d;
  logic                      calc_first_q, calc_first_d;
  logic                      layer_done_q, layer_done_d;
  logic [CNT_W-1:0]          fetch_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fcnt_q       <= '0;
      addr_q       <= '0;
      row_q        <= '0;
      feat_q       <= '0;
      calc_first_q <= 1'b0;
      layer_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      addr_q       <= addr_d;
      row_q        <= row_d;
      feat_q       <= feat_d;
      calc_first_q <= calc_first_d;
      layer_done_q <= layer_done_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    fcnt_d          = fcnt_q;
    addr_d          = addr_q;
    row_d           = row_q;
    feat_d          = feat_q;
    calc_first_d    = 1'b0;
    layer_done_d    = 1'b0;
    fetch_valid     = 1'b0;
    calc_start      = 1'b0;
    kernel_calc_fin = 1'b0;
    busy            = 1'b1;
    fetch_last      = (state_q == StPreload) ? PRELOAD_LAST : SHIFT_LAST;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (enable) begin
          state_d = StPreload;
          fcnt_d  = '0;
          addr_d  = '0;
          row_d   = '0;
          feat_d  = '0;
        end
      end
      StPreload, StShift: begin
        fetch_valid = 1'b1;
        // The address stays on the last fetched pixel so it holds while idle.
        if (fcnt_q == fetch_last) begin
          state_d      = StCalc;
          fcnt_d       = '0;
          calc_first_d = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
      StCalc: begin
        calc_start = calc_first_q;
        if (!calc_first_q && calc_done) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        kernel_calc_fin = 1'b1;
        if (pool_ready) begin
          if (row_q < ROW_LAST) begin
            row_d   = row_q + 3'd1;
            addr_d  = addr_q + 1'b1;
            state_d = StShift;
          end else if (feat_q < FEAT_LAST) begin
            feat_d  = feat_q + 2'd1;
            row_d   = '0;
            addr_d  = '0;
            state_d = StPreload;
          end else begin
            state_d      = StDone;
            layer_done_d = 1'b1;
          end
        end
      end
      StDone: begin
        busy = 1'b0;
        if (!enable) begin
          state_d = StIdle;
          addr_d  = '0;
          row_d   = '0;
          feat_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ext_rom_addr = addr_q;
  assign out_row_idx  = row_q;
  assign feature_idx  = feat_q;
  assign layer_done   = layer_done_q;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Bench for conv_layer_scheduler: a loop-structured schedule model predicts every output
// each cycle while driving randomized handshake timing and ignored-input noise.
module tb_conv_layer_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       calc_done;
  logic       pool_ready;
  logic [7:0] ext_rom_addr;
  logic       fetch_valid;
  logic       calc_start;
  logic       kernel_calc_fin;
  logic [2:0] out_row_idx;
  logic [1:0] feature_idx;
  logic       busy;
  logic       layer_done;

  always #5 clk = ~clk;

  conv_layer_scheduler #(
    .IMAGE_SIZE    (8),
    .KERNEL_SIZE   (3),
    .FEATURE_NUM   (3),
    .EXT_ADDR_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .calc_done      (calc_done),
    .pool_ready     (pool_ready),
    .ext_rom_addr   (ext_rom_addr),
    .fetch_valid    (fetch_valid),
    .calc_start     (calc_start),
    .kernel_calc_fin(kernel_calc_fin),
    .out_row_idx    (out_row_idx),
    .feature_idx    (feature_idx),
    .busy           (busy),
    .layer_done     (layer_done)
  );

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          xfer_cnt = 0;
  int          fetch_cnt = 0;
  int          kcf_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  logic        chk_en = 1'b0;
  logic [17:0] exp_vec = '0;
  logic [17:0] act_vec;
  int          lit_seq = 0;
  int          lit_seen = 0;
  int          lit_act = 0;
  int          lit_exp = 0;
  string       lit_name = "";

  function automatic logic [17:0] pk(input int addr, input logic fv, input logic cs,
                                     input logic kcf, input int row, input int feat,
                                     input logic bsy, input logic ld);
    return {8'(addr), fv, cs, kcf, 3'(row), 2'(feat), bsy, ld};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Single checker: per-cycle output vector plus literal checks posted by the driver.
  always @(negedge clk) begin
    act_vec = {ext_rom_addr, fetch_valid, calc_start, kernel_calc_fin, out_row_idx,
               feature_idx, busy, layer_done};
    if (chk_en) begin
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL outputs cyc=%0d {addr,fv,cs,kcf,row,feat,busy,ld} act=%h exp=%h",
                 cyc, act_vec, exp_vec);
      end
    end
    if (fetch_valid) fetch_cnt++;
    if (kernel_calc_fin) kcf_cnt++;
    if (kernel_calc_fin && pool_ready) xfer_cnt++;
    if (layer_done) done_cyc = cyc;
    if (lit_seq != lit_seen) begin
      total++;
      if (lit_act != lit_exp) begin
        bad++;
        $display("FAIL %s act=%0d exp=%0d", lit_name, lit_act, lit_exp);
      end
      lit_seen = lit_seq;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string name, input int act, input int expv);
    lit_name = name;
    lit_act  = act;
    lit_exp  = expv;
    lit_seq++;
    tick();
  endtask

  // Inputs that must be ignored during fetch cycles.
  task automatic noise(input int mode);
    case (mode)
      0: begin enable = 1'b1; calc_done = 1'b0; pool_ready = 1'b1; end
      1: begin enable = 1'b0; calc_done = 1'b1; pool_ready = 1'b0; end
      default: begin enable = rbit(); calc_done = rbit(); pool_ready = rbit(); end
    endcase
  endtask

  task automatic do_reset();
    #2;
    rst_n   = 1'b0;
    exp_vec = '0;
    #1;
    lit_name = "async_reset_outputs";
    lit_act  = int'({ext_rom_addr, fetch_valid, calc_start, kernel_calc_fin, out_row_idx,
                     feature_idx, busy, layer_done});
    lit_exp  = 0;
    lit_seq++;
    enable = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One layer run: IDLE sample, 3 features x 6 rows, DONE hold, back to IDLE.
  task automatic run_layer(input int mode, input int ab_f, input int ab_r, input int ab_k,
                           input int hold);
    int n, base, last, d, w;
    exp_vec    = '0;
    enable     = 1'b1;
    calc_done  = rbit();
    pool_ready = rbit();
    start_cyc  = cyc;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < 6; r++) begin
        n    = (r == 0) ? 24 : 8;
        base = (r == 0) ? 0 : (r + 2) * 8;
        last = base + n - 1;
        for (int k = 0; k < n; k++) begin
          if (f == ab_f && r == ab_r && k == ab_k) begin
            do_reset();
            return;
          end
          exp_vec = pk(base + k, 1'b1, 1'b0, 1'b0, r, f, 1'b1, 1'b0);
          noise(mode);
          tick();
        end
        d = (mode == 2) ? int'($urandom_range(1, 4)) : (mode == 1 && f == 0 && r == 1) ? 20 : 1;
        w = (mode == 2) ? int'($urandom_range(0, 3)) : (mode == 1 && f == 0 && r == 2) ? 10 : 0;
        exp_vec    = pk(last, 1'b0, 1'b1, 1'b0, r, f, 1'b1, 1'b0);
        calc_done  = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : rbit();
        pool_ready = (mode == 2) ? rbit() : 1'b1;
        if (mode == 2) enable = rbit();
        tick();
        for (int j = 1; j <= d; j++) begin
          exp_vec    = pk(last, 1'b0, 1'b0, 1'b0, r, f, 1'b1, 1'b0);
          calc_done  = (j == d);
          pool_ready = (mode == 2) ? rbit() : 1'b1;
          tick();
        end
        for (int j = 0; j <= w; j++) begin
          exp_vec    = pk(last, 1'b0, 1'b0, 1'b1, r, f, 1'b1, 1'b0);
          pool_ready = (j == w);
          calc_done  = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : rbit();
          tick();
        end
      end
    end
    for (int j = 0; j <= hold; j++) begin
      exp_vec    = pk(63, 1'b0, 1'b0, 1'b0, 5, 2, 1'b0, (j == 0));
      enable     = (j < hold);
      calc_done  = rbit();
      pool_ready = rbit();
      tick();
    end
    exp_vec    = '0;
    enable     = 1'b0;
    calc_done  = 1'b0;
    pool_ready = 1'b0;
    tick();
  endtask

  initial begin
    int x0, f0, k0;
    rst_n      = 1'b1;
    enable     = 1'b0;
    calc_done  = 1'b0;
    pool_ready = 1'b0;
    #2;
    rst_n  = 1'b0;
    chk_en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      enable     = 1'b0;
      calc_done  = rbit();
      pool_ready = rbit();
      tick();
    end
    calc_done  = 1'b0;
    pool_ready = 1'b0;

    x0 = xfer_cnt;
    f0 = fetch_cnt;
    run_layer(0, -1, -1, -1, 5);
    post("row_transfers", xfer_cnt - x0, 18);
    post("fetch_cycles", fetch_cnt - f0, 192);
    post("enable_to_layer_done", done_cyc - start_cyc, 247);

    k0 = kcf_cnt;
    run_layer(1, -1, -1, -1, 2);
    post("kcf_cycles_with_stall", kcf_cnt - k0, 28);

    run_layer(2, 1, 3, 3, 1);
    f0 = fetch_cnt;
    run_layer(2, -1, -1, -1, 0);
    post("fetch_cycles_after_reset", fetch_cnt - f0, 192);
    for (int i = 0; i < 3; i++) run_layer(2, -1, -1, -1, 3);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
